cpu_writeback: RTL and testbench



---
 rtl/cpu_writeback.sv | 145 ++++++++++++++
 tb/tb_cpu_writeback.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_writeback.sv
//==============================================================================
// cpu_writeback -- register-file writer: ALU results pass straight through,
// loads wait for memory, get byte/half-selected and extended, and stall upstream.
// Revision: 1.0
//==============================================================================
`default_nettype none

module cpu_writeback #(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_is_load,
    input  logic [2:0]      ex_funct3,
    input  logic [1:0]      ex_addr_lo,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] d,
    output logic            stall_pipeline,
    output logic            load_err
);

    localparam int          CW      = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CW-1:0] c_CNT_LAST = CW'(LOAD_TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_count, w_count_nxt;
    logic [4:0]        r_lat_rd, w_lat_rd_nxt;
    logic [2:0]        r_lat_f3, w_lat_f3_nxt;
    logic [1:0]        r_lat_addr, w_lat_addr_nxt;
    logic [4:0]        r_rd, w_rd_nxt;
    logic [XLEN-1:0]   r_d, w_d_nxt;
    logic              r_err, w_err_nxt;
    logic              w_stall;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_ext;

    // Lane selection uses the address captured at load acceptance.
    always_comb begin
        w_byte = 8'h00;
        case (r_lat_addr)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_lat_f3)
            3'b000:  w_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_lat_rd_nxt   = r_lat_rd;
        w_lat_f3_nxt   = r_lat_f3;
        w_lat_addr_nxt = r_lat_addr;
        w_rd_nxt       = 5'd0;
        w_d_nxt        = r_d;
        w_err_nxt      = r_err;
        w_stall        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_rvalid) begin
                    w_err_nxt = 1'b1;
                end
                if (ex_valid) begin
                    if (ex_is_load) begin
                        w_lat_rd_nxt   = ex_rd;
                        w_lat_f3_nxt   = ex_funct3;
                        w_lat_addr_nxt = ex_addr_lo;
                        w_count_nxt    = '0;
                        w_state_nxt    = S_WAIT;
                        w_stall        = 1'b1;
                    end else begin
                        w_rd_nxt = ex_rd;
                        w_d_nxt  = ex_result;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_rd_nxt    = r_lat_rd;
                    w_d_nxt     = w_ext;
                    w_state_nxt = S_IDLE;
                end else if (r_count == c_CNT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                    w_stall     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_lat_rd   <= 5'd0;
            r_lat_f3   <= 3'd0;
            r_lat_addr <= 2'd0;
            r_rd       <= 5'd0;
            r_d        <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_lat_rd   <= w_lat_rd_nxt;
            r_lat_f3   <= w_lat_f3_nxt;
            r_lat_addr <= w_lat_addr_nxt;
            r_rd       <= w_rd_nxt;
            r_d        <= w_d_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Gating with n_rst keeps stall low while reset is held, even with a load on the inputs.
    assign stall_pipeline = w_stall & n_rst;
    assign rd             = r_rd;
    assign d              = r_d;
    assign load_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cpu_writeback.sv
`default_nettype none

module tb_cpu_writeback;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        stall_pipeline;
    logic        load_err;

    int checks = 0;
    int errors = 0;
    logic [36:0] sb_q[$];

    cpu_writeback #(.XLEN(32), .LOAD_TIMEOUT(16)) dut (
        .clk(clk), .n_rst(n_rst),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_result(ex_result),
        .ex_is_load(ex_is_load), .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rd(rd), .d(d), .stall_pipeline(stall_pipeline), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (n_rst === 1'b1 && rd !== 5'd0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got rd=%0d d=%h expected no write", rd, d);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                chk("wr_rd", {27'd0, rd}, {27'd0, e[36:32]});
                chk("wr_d", d, e[31:0]);
            end
        end
    end

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_rd = 5'd0; ex_result = 32'd0; ex_is_load = 1'b0;
        ex_funct3 = 3'd0; ex_addr_lo = 2'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] v);
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = r; ex_result = v;
        if (r != 5'd0) sb_q.push_back({r, v});
    endtask

    // Issue a load, answer it 'dly' cycles later, and check stall on every cycle.
    task automatic do_load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] a,
                           input int dly, input logic [31:0] rdata, input logic [31:0] exp);
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = r; ex_funct3 = f3; ex_addr_lo = a;
        ex_result = 32'hBAD0_BAD0;
        #1 chk("stall_issue", {31'd0, stall_pipeline}, 32'd1);
        for (int i = 1; i < dly; i++) begin
            @(negedge clk);
            ex_valid = 1'b0;
            #1 chk("stall_wait", {31'd0, stall_pipeline}, 32'd1);
        end
        @(negedge clk);
        ex_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        if (r != 5'd0) sb_q.push_back({r, exp});
        #1 chk("stall_resp", {31'd0, stall_pipeline}, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        n_rst = 1'b0;
        ex_valid = 1'b1; ex_is_load = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_d", d, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        chk("rst_stall", {31'd0, stall_pipeline}, 32'd0);
        idle_inputs();
        @(negedge clk);
        n_rst = 1'b1;

        // ALU write then hold
        alu(5'd7, 32'h0000_00AF);
        @(negedge clk); idle_inputs();
        @(negedge clk); #1;
        chk("alu_rd_clear", {27'd0, rd}, 32'd0);
        chk("alu_d_hold", d, 32'h0000_00AF);

        // Loads
        do_load(5'd5, 3'b000, 2'd2, 3, 32'h1280_3456, 32'hFFFF_FF80);
        do_load(5'd6, 3'b101, 2'd2, 1, 32'h8001_0000, 32'h0000_8001);
        do_load(5'd8, 3'b001, 2'd2, 2, 32'h8001_0000, 32'hFFFF_8001);
        do_load(5'd9, 3'b010, 2'd3, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load(5'd10, 3'b100, 2'd1, 2, 32'h0000_F100, 32'h0000_00F1);
        do_load(5'd11, 3'b001, 2'd1, 1, 32'hFFFF_7FFF, 32'h0000_7FFF);
        do_load(5'd12, 3'b110, 2'd1, 1, 32'h1234_5678, 32'h1234_5678);
        do_load(5'd0, 3'b000, 2'd0, 1, 32'h0000_00FF, 32'h0);
        #1 chk("err_clean", {31'd0, load_err}, 32'd0);

        // Timeout: 16 stall cycles, then abort
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd13; ex_funct3 = 3'b010;
        #1 chk("to_stall_issue", {31'd0, stall_pipeline}, 32'd1);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk); ex_valid = 1'b0;
            #1 chk("to_stall", {31'd0, stall_pipeline}, 32'd1);
        end
        @(negedge clk); #1;
        chk("to_stall_drop", {31'd0, stall_pipeline}, 32'd0);
        chk("to_err_pre", {31'd0, load_err}, 32'd0);
        @(negedge clk); #1;
        chk("to_err", {31'd0, load_err}, 32'd1);
        chk("to_rd", {27'd0, rd}, 32'd0);
        alu(5'd14, 32'h0000_1234);
        @(negedge clk); idle_inputs();

        // Reset clears the sticky error; stray response sets it again
        @(negedge clk); n_rst = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        #1 chk("rst2_err", {31'd0, load_err}, 32'd0);
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk); mem_rvalid = 1'b0; #1;
        chk("stray_err", {31'd0, load_err}, 32'd1);
        chk("stray_rd", {27'd0, rd}, 32'd0);

        // Back-to-back ALU writes
        alu(5'd1, 32'h0000_0011);
        alu(5'd2, 32'h0000_0022);
        alu(5'd3, 32'h0000_0033);
        @(negedge clk); idle_inputs();
        #1 chk("b2b_last_rd", {27'd0, rd}, 32'd3);

        // Reset in the middle of a load
        @(negedge clk); n_rst = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd20; ex_funct3 = 3'b010;
        @(negedge clk); ex_valid = 1'b0;
        #1 chk("mid_stall_pre", {31'd0, stall_pipeline}, 32'd1);
        #1 n_rst = 1'b0;
        #1;
        chk("mid_stall", {31'd0, stall_pipeline}, 32'd0);
        chk("mid_rd", {27'd0, rd}, 32'd0);
        chk("mid_d", d, 32'd0);
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk); #1;
        chk("mid_idle_stall", {31'd0, stall_pipeline}, 32'd0);
        chk("mid_err_pre", {31'd0, load_err}, 32'd0);
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk); mem_rvalid = 1'b0; #1;
        chk("late_err", {31'd0, load_err}, 32'd1);
        chk("late_rd", {27'd0, rd}, 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
